// File: rtl/bus_arbiter_2way.sv
// ---------------------------------------------------------------------------
// bus_arbiter_2way
//
// Round-robin arbiter that shares one DATA_W-bit resource (write-back bus or
// memory port) between two requesters: requester 0 (core) and requester 1
// (loader/debug port). A grant is held for a burst of words and released on
// the requester's "last" flag, after MAX_BURST accepted words, or when the
// requester drops its request. There is always at least one IDLE cycle
// between two grants.
//
// Handshake: a word moves from the granted requester to the resource in
// every cycle where res_valid and res_ready are both high. That same cycle
// is signalled back to the owner as ackk. The owner holds its word, data and
// last flag stable until it sees ackk, or drops reqk to give up the grant.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   req0/1     requester has a word valid
//   data0/1    requester word
//   last0/1    word is the final word of the requester's burst
//   res_ready  resource accepts a word this cycle
//   gnt0/1     requester owns the resource (registered)
//   ack0/1     requester word accepted this cycle
//   res_sel    shared data mux select, 0 = data0, 1 = data1 (registered)
//   res_valid  word presented to the resource
//   res_data   word presented to the resource (0 while nobody is granted)
//   state_dbg  current FSM state: 0 = IDLE, 1 = OWN0, 2 = OWN1
// ---------------------------------------------------------------------------
module bus_arbiter_2way #(
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [DATA_W-1:0] data0,
    input  logic              last0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    input  logic              last1,
    input  logic              res_ready,
    output logic              gnt0,
    output logic              gnt1,
    output logic              ack0,
    output logic              ack1,
    output logic              res_sel,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    // Count value held while the final word of a maximum-length burst is on
    // the bus; accepting that word forces the release.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    state_t           state;
    logic             rr_last;   // requester that owned the last grant
    logic [CNT_W-1:0] count;     // words accepted in the current grant

    logic owned;
    logic own_req;
    logic own_last;
    logic own_ack;

    // While granted, res_sel always equals the owner index, so it also
    // selects the owner's request and last flag.
    always_comb begin
        owned     = gnt0 | gnt1;
        own_req   = res_sel ? req1  : req0;
        own_last  = res_sel ? last1 : last0;
        res_valid = owned & own_req;
        res_data  = owned ? (res_sel ? data1 : data0) : '0;
        ack0      = gnt0 & req0 & res_ready;
        ack1      = gnt1 & req1 & res_ready;
        own_ack   = ack0 | ack1;
    end

    assign state_dbg = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            res_sel <= 1'b0;
            count   <= '0;
            rr_last <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        count <= '0;
                        // On a tie the requester that did not own the last
                        // grant wins.
                        if (req0 && (!req1 || rr_last)) begin
                            state   <= OWN0;
                            gnt0    <= 1'b1;
                            res_sel <= 1'b0;
                        end else begin
                            state   <= OWN1;
                            gnt1    <= 1'b1;
                            res_sel <= 1'b1;
                        end
                    end
                end
                OWN0, OWN1: begin
                    // Release on abandon, on the last word, or when the
                    // burst limit is reached. A stalled word (res_ready low)
                    // changes nothing.
                    if (!own_req || (own_ack && (own_last || count == CNT_LAST))) begin
                        state   <= IDLE;
                        gnt0    <= 1'b0;
                        gnt1    <= 1'b0;
                        rr_last <= res_sel;
                    end else if (own_ack) begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter_2way.sv
module tb_bus_arbiter_2way;

    localparam int DATA_W    = 16;
    localparam int MAX_BURST = 8;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              reset;
    logic              req0, req1, last0, last1, res_ready;
    logic [DATA_W-1:0] data0, data1;
    logic              gnt0, gnt1, ack0, ack1, res_sel, res_valid;
    logic [DATA_W-1:0] res_data;
    logic [1:0]        state_dbg;

    always #5 clk = ~clk;

    bus_arbiter_2way #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .data0(data0), .last0(last0),
        .req1(req1), .data1(data1), .last1(last1),
        .res_ready(res_ready),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
        .res_sel(res_sel), .res_valid(res_valid), .res_data(res_data),
        .state_dbg(state_dbg)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- scoreboard / reference model ----------------
    logic [DATA_W-1:0] exp_q[$];

    // Owner: -1 = nobody, 0 or 1 = requester index.
    int m_owner;
    int m_words;
    int m_rr_last;
    int m_sel;

    task automatic model_reset();
        m_owner   = -1;
        m_words   = 0;
        m_rr_last = 1;
        m_sel     = 0;
    endtask

    // Advance the model across one clock edge using the current inputs.
    task automatic model_step();
        bit r, l;
        if (m_owner < 0) begin
            if (req0 && req1)  m_owner = 1 - m_rr_last;
            else if (req0)     m_owner = 0;
            else if (req1)     m_owner = 1;
            if (m_owner >= 0) begin
                m_sel   = m_owner;
                m_words = 0;
            end
        end else begin
            r = (m_owner == 0) ? req0  : req1;
            l = (m_owner == 0) ? last0 : last1;
            if (!r) begin
                m_rr_last = m_owner;
                m_owner   = -1;
            end else if (res_ready) begin
                m_words++;
                if (l || m_words == MAX_BURST) begin
                    m_rr_last = m_owner;
                    m_owner   = -1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0 = 0; req1 = 0; last0 = 0; last1 = 0;
        data0 = '0; data1 = '0; res_ready = 1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #1;
        checks++;
        if ({gnt0, gnt1, ack0, ack1, res_valid, res_sel} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=000000", {gnt0, gnt1, ack0, ack1, res_valid, res_sel});
        end
        checks++;
        if (res_data !== 16'h0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0000", res_data);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        tick();
    endtask

    task automatic test_single_word();
        req0 = 1; data0 = 16'h1234; last0 = 1; res_ready = 1;
        #1;
        checks++;
        if ({gnt0, ack0, res_valid} !== 3'b000) begin
            failures++;
            $display("FAIL single_idle got=%b exp=000", {gnt0, ack0, res_valid});
        end
        tick();
        checks++;
        if ({gnt0, gnt1, res_sel, ack0, ack1, res_valid} !== 6'b100101) begin
            failures++;
            $display("FAIL single_grant got=%b exp=100101", {gnt0, gnt1, res_sel, ack0, ack1, res_valid});
        end
        checks++;
        if (res_data !== 16'h1234) begin
            failures++;
            $display("FAIL single_data got=%h exp=1234", res_data);
        end
        req0 = 0; last0 = 0;
        tick();
        checks++;
        if ({gnt0, gnt1} !== 2'b00) begin
            failures++;
            $display("FAIL single_release got=%b exp=00", {gnt0, gnt1});
        end
    endtask

    // Requester 0 owned the last grant, so the first tie goes to requester 1.
    task automatic test_alternate();
        logic [2:0] exp_v;
        req0 = 1; req1 = 1; last0 = 1; last1 = 1;
        data0 = 16'h0A0A; data1 = 16'h1B1B; res_ready = 1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i % 2 == 1) exp_v = (((i - 1) / 2) % 2 == 0) ? 3'b011 : 3'b100;
            else            exp_v = {2'b00, ((i / 2) % 2 == 1)};  // res_sel holds in IDLE
            checks++;
            if ({gnt0, gnt1, res_sel} !== exp_v) begin
                failures++;
                $display("FAIL alternate_cycle%0d got=%b exp=%b", i, {gnt0, gnt1, res_sel}, exp_v);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_forced_release();
        int  done = 0;
        int  cyc  = 0;
        int  grants = 0;
        bit  chk_idle = 0;
        bit  prev_g = 0;
        exp_q.delete();
        for (int i = 0; i < 12; i++) exp_q.push_back(16'hA000 + 16'(i));
        res_ready = 1;
        while (done < 12 && cyc < 60) begin
            req1 = 1; data1 = 16'hA000 + 16'(done); last1 = (done == 11);
            #1;
            if (gnt1 && !prev_g) grants++;
            prev_g = gnt1;
            if (chk_idle) begin
                checks++;
                if ({gnt1, ack1} !== 2'b00) begin
                    failures++;
                    $display("FAIL forced_idle got=%b exp=00", {gnt1, ack1});
                end
                chk_idle = 0;
            end
            if (ack1 === 1'b1) begin
                checks++;
                if (res_data !== exp_q[0]) begin
                    failures++;
                    $display("FAIL forced_word%0d got=%h exp=%h", done, res_data, exp_q[0]);
                end
                void'(exp_q.pop_front());
                done++;
                if (done == MAX_BURST) chk_idle = 1;
            end
            tick();
            cyc++;
        end
        idle_inputs();
        #1;
        checks++;
        if (done != 12 || gnt1 !== 1'b0) begin
            failures++;
            $display("FAIL forced_total words=%0d gnt1=%b exp words=12 gnt1=0", done, gnt1);
        end
        checks++;
        if (grants != 2) begin
            failures++;
            $display("FAIL forced_grants got=%0d exp=2", grants);
        end
    endtask

    task automatic test_stall();
        int done = 0;
        int stalls = 0;
        int cyc = 0;
        logic [DATA_W-1:0] w;
        idle_inputs();
        while (done < MAX_BURST && cyc < 40) begin
            req0 = 1;
            w = (done == 3) ? 16'hBEEF : 16'h0100 + 16'(done);
            data0 = w;
            res_ready = !(gnt0 && done == 3 && stalls < 3);
            #1;
            if (gnt0 && !res_ready) begin
                checks++;
                if ({res_valid, ack0} !== 2'b10 || res_data !== 16'hBEEF) begin
                    failures++;
                    $display("FAIL stall_hold valid=%b ack0=%b data=%h exp valid=1 ack0=0 data=beef",
                             res_valid, ack0, res_data);
                end
                stalls++;
            end
            if (ack0 === 1'b1) begin
                checks++;
                if (res_data !== w) begin
                    failures++;
                    $display("FAIL stall_word%0d got=%h exp=%h", done, res_data, w);
                end
                done++;
            end
            tick();
            cyc++;
        end
        idle_inputs();
        #1;
        // Forced release after 8 accepted words proves stalls did not count.
        checks++;
        if (done != MAX_BURST || stalls != 3 || gnt0 !== 1'b0) begin
            failures++;
            $display("FAIL stall_release words=%0d stalls=%0d gnt0=%b exp words=8 stalls=3 gnt0=0",
                     done, stalls, gnt0);
        end
    endtask

    task automatic test_abandon();
        idle_inputs();
        req1 = 1; data1 = 16'h5150; last1 = 0;
        tick();
        for (int i = 0; i < 2; i++) begin
            data1 = 16'h5150 + 16'(i);
            #1;
            checks++;
            if ({gnt1, ack1, res_valid} !== 3'b111 || res_data !== data1) begin
                failures++;
                $display("FAIL abandon_word%0d ctrl=%b data=%h exp ctrl=111 data=%h",
                         i, {gnt1, ack1, res_valid}, res_data, data1);
            end
            tick();
        end
        req1 = 0;
        #1;
        checks++;
        if ({gnt1, ack1, res_valid} !== 3'b100) begin
            failures++;
            $display("FAIL abandon_drop got=%b exp=100", {gnt1, ack1, res_valid});
        end
        tick();
        checks++;
        if ({gnt0, gnt1} !== 2'b00) begin
            failures++;
            $display("FAIL abandon_idle got=%b exp=00", {gnt0, gnt1});
        end
        // rr_last is now 1, so a tie must go to requester 0.
        req0 = 1; req1 = 1; last0 = 1; last1 = 1; data0 = 16'h0F0F;
        tick();
        checks++;
        if ({gnt0, gnt1, ack0} !== 3'b101) begin
            failures++;
            $display("FAIL abandon_tie got=%b exp=101", {gnt0, gnt1, ack0});
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid_burst();
        idle_inputs();
        req0 = 1; last0 = 0; data0 = 16'hC000;
        tick();
        for (int i = 0; i < 2; i++) begin
            data0 = 16'hC000 + 16'(i);
            tick();
        end
        data0 = 16'hC002;
        #1;
        checks++;
        if ({gnt0, ack0} !== 2'b11) begin
            failures++;
            $display("FAIL midrst_pre got=%b exp=11", {gnt0, ack0});
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({gnt0, ack0, res_valid} !== 3'b000) begin
            failures++;
            $display("FAIL midrst_drop got=%b exp=000", {gnt0, ack0, res_valid});
        end
        req0 = 1; req1 = 1; last0 = 1; last1 = 1;
        @(posedge clk);
        @(negedge clk) reset = 1'b0;
        tick();
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            failures++;
            $display("FAIL midrst_tie got=%b exp=10", {gnt0, gnt1});
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        logic [5:0]        e_ctrl;
        logic [DATA_W-1:0] e_data;
        logic              e_r;
        idle_inputs();
        reset = 1'b1;
        #1;
        model_reset();
        @(negedge clk) reset = 1'b0;
        tick();
        for (int c = 0; c < 400; c++) begin
            req0  = req0 ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
            req1  = req1 ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
            last0 = ($urandom_range(0, 11) == 0);
            last1 = ($urandom_range(0, 11) == 0);
            data0 = 16'($urandom);
            data1 = 16'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            #1;
            e_r    = (m_owner == 0) ? req0 : req1;
            e_ctrl = {m_owner == 0, m_owner == 1,
                      m_owner == 0 && req0 && res_ready,
                      m_owner == 1 && req1 && res_ready,
                      m_owner >= 0 && e_r,
                      m_sel == 1};
            e_data = (m_owner < 0) ? '0 : ((m_owner == 0) ? data0 : data1);
            checks++;
            if ({gnt0, gnt1, ack0, ack1, res_valid, res_sel} !== e_ctrl) begin
                failures++;
                $display("FAIL random_ctrl cycle=%0d got=%b exp=%b", c,
                         {gnt0, gnt1, ack0, ack1, res_valid, res_sel}, e_ctrl);
            end
            checks++;
            if (res_data !== e_data) begin
                failures++;
                $display("FAIL random_data cycle=%0d got=%h exp=%h", c, res_data, e_data);
            end
            model_step();
            tick();
        end
        idle_inputs();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        idle_inputs();
        reset = 1'b0;
        #1;
        test_reset();
        test_single_word();
        test_alternate();
        test_forced_release();
        test_stall();
        test_abandon();
        test_reset_mid_burst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_2way.md
Name: bus_arbiter_2way

Overview:
- Round-robin arbiter that shares one 16-bit datapath resource (write-back bus / memory port) between two requesters.
- Drives the select line of the shared 2:1 16-bit data mux and forwards the granted requester's words to the resource.
- Uses a valid/ready handshake and supports bursts that end on a "last" flag.
- Sits between the CPU datapath requesters (requester 0 = core, requester 1 = loader/debug port) and the shared resource.

Parameters:
- DATA_W, 16, width of data words.
- MAX_BURST, 8, maximum words per grant before forced release (1..2^CNT_W).
- CNT_W, 3, width of the internal burst counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req0  input  1  requester 0 has a word valid.
- data0  input  DATA_W  requester 0 word.
- last0  input  1  requester 0 word is the final word of its burst.
- req1  input  1  requester 1 has a word valid.
- data1  input  DATA_W  requester 1 word.
- last1  input  1  requester 1 word is the final word of its burst.
- res_ready  input  1  resource accepts a word this cycle.
- gnt0  output  1  requester 0 owns the resource (registered).
- gnt1  output  1  requester 1 owns the resource (registered).
- ack0  output  1  requester 0 word accepted this cycle.
- ack1  output  1  requester 1 word accepted this cycle.
- res_sel  output  1  mux select (0 = data0, 1 = data1), registered.
- res_valid  output  1  word presented to the resource.
- res_data  output  DATA_W  word presented to the resource.

Behaviour:
- Reset (async, immediate):
  - State IDLE; gnt0 = gnt1 = 0; res_sel = 0; burst count = 0.
  - rr_last = 1, so requester 0 wins the first tie.
  - res_valid = 0; ack0 = ack1 = 0; res_data = 0 while not granted.
- States: IDLE, OWN0, OWN1.
  - gnt0 = (state == OWN0); gnt1 = (state == OWN1). The two are never high together.
- IDLE:
  - req0 & !req1 -> OWN0. req1 & !req0 -> OWN1.
  - Both requesting -> OWNk where k = !rr_last.
  - Neither requesting -> stay in IDLE.
  - On entering OWNk: res_sel <= k and count <= 0.
  - Grant latency is 1 cycle from req to gnt. No words transfer while in IDLE.
- OWNk, combinational outputs:
  - res_valid = reqk.
  - res_data = datak (mux driven by res_sel).
  - ackk = reqk & res_ready; the other requester's ack = 0.
- OWNk, transfer: on ackk, count increments.
- OWNk, release to IDLE next cycle with rr_last <= k when any of these holds:
  - ackk & lastk.
  - ackk & (count == MAX_BURST-1), a forced release even without last.
  - !reqk, i.e. the requester abandoned the grant; no word transfers that cycle.
- Always at least 1 IDLE cycle between grants. There is no grant-to-grant bypass.
- res_ready low while granted: hold state, count and outputs. There is no timeout.
- res_sel keeps its last value in IDLE.
- A forced-release requester must re-request and re-arbitrate. With contention, the other side wins next.
- Inputs of the non-granted requester are ignored entirely.
- Reset asserted mid-burst: grant drops immediately and the partial burst is discarded. Requesters must restart.

Test Plan:
- Reset, then req0 = 1 with data0 = 0x1234, last0 = 1, res_ready = 1.
  - Cycle 1: gnt0 = 1, res_sel = 0.
  - Same cycle: res_data = 0x1234, ack0 = 1.
  - Next cycle: IDLE, gnt0 = 0.
- req0 and req1 both held continuously, single-word bursts (last = 1).
  - Grants alternate 0, 1, 0, 1, with 1 IDLE cycle between each.
  - res_sel toggles to match.
- req1 burst of 12 words (last1 only on word 12), res_ready = 1.
  - Forced release after word 8 (count = 7) goes to IDLE.
  - If req0 is pending, requester 0 is granted next; otherwise requester 1 is re-granted and sends words 9..12.
- While OWN0, res_ready = 0 for 3 cycles with data0 = 0xBEEF.
  - res_valid = 1, res_data = 0xBEEF, ack0 = 0, and count stays unchanged.
  - Transfer occurs on the cycle res_ready returns to 1.
- While OWN1, drop req1 mid-burst after 2 words.
  - Next cycle IDLE, no ack on the drop cycle, rr_last = 1.
- Assert reset during a 4-word burst on requester 0 after word 2.
  - gnt0, ack0 and res_valid go to 0 immediately.
  - After reset release, a tie is granted to requester 0.
